adl_seq: RTL and testbench

- Sequencer for the m6502 low-address mux and its L register.
- Accepts one addressing-mode request at a time and steps through the required bus cycles. Each cycle it drives the mux select (PCL / D reg / S reg / L reg) and the L-register load enable.
- Handles memory wait states and flags an error on a stalled bus through a watchdog.
- Sits between the instruction decoder and the low-address mux.

---
 rtl/adl_seq.sv | 161 ++++++++++++++++
 tb/tb_adl_seq.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adl_seq.sv
// Low-address mux sequencer for the m6502 datapath: steps FETCH/ZP/STK/ZPX/ZPX_RMW bus cycles,
// drives the mux select and L-register load, and aborts stalled bus cycles via a wait watchdog.
// Optional build macro ADL_SEQ_STALLCNT_EN adds a 16-bit saturating total-stall counter on stall_cnt.
module adl_seq #(
  parameter int unsigned WAIT_LIMIT = 15,
  parameter int unsigned CNT_W      = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  mode,
  input  logic        rdy,
  output logic [1:0]  sel,
  output logic        lreg_ld,
  output logic        addr_vld,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] stall_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ZP,
    S_STK,
    S_IDX_LD,
    S_IDX_USE,
    S_IDX_USE2,
    S_DONE
  } state_t;

  localparam logic [1:0] SEL_PCL = 2'b00;
  localparam logic [1:0] SEL_D   = 2'b01;
  localparam logic [1:0] SEL_S   = 2'b10;
  localparam logic [1:0] SEL_L   = 2'b11;

  localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(WAIT_LIMIT);

  state_t           state_reg, state_next;
  logic             rmw_reg, rmw_next;
  logic             err_reg, err_next;
  logic [1:0]       sel_reg, sel_next;
  logic [CNT_W-1:0] wait_reg, wait_next;
  logic             bus_state;

  assign bus_state = (state_reg == S_FETCH) || (state_reg == S_ZP) || (state_reg == S_STK) ||
                     (state_reg == S_IDX_USE) || (state_reg == S_IDX_USE2);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= S_IDLE;
      rmw_reg   <= 1'b0;
      err_reg   <= 1'b0;
      sel_reg   <= SEL_PCL;
      wait_reg  <= '0;
    end else begin
      state_reg <= state_next;
      rmw_reg   <= rmw_next;
      err_reg   <= err_next;
      sel_reg   <= sel_next;
      wait_reg  <= wait_next;
    end
  end

  // Next-state logic; err_next is only ever set on a transition into DONE.
  always_comb begin
    state_next = state_reg;
    rmw_next   = rmw_reg;
    err_next   = 1'b0;
    wait_next  = wait_reg;
    case (state_reg)
      S_IDLE: begin
        wait_next = '0;
        if (start) begin
          case (mode)
            3'b000: state_next = S_FETCH;
            3'b001: state_next = S_ZP;
            3'b010: state_next = S_STK;
            3'b011: begin
              state_next = S_IDX_LD;
              rmw_next   = 1'b0;
            end
            3'b100: begin
              state_next = S_IDX_LD;
              rmw_next   = 1'b1;
            end
            default: begin
              state_next = S_DONE;
              err_next   = 1'b1;
            end
          endcase
        end
      end
      S_IDX_LD: begin
        state_next = S_IDX_USE;
        wait_next  = '0;
      end
      S_FETCH, S_ZP, S_STK, S_IDX_USE, S_IDX_USE2: begin
        if (rdy) begin
          wait_next = '0;
          if (state_reg == S_IDX_USE && rmw_reg) state_next = S_IDX_USE2;
          else                                   state_next = S_DONE;
        end else if (wait_reg == WAIT_MAX) begin
          // This cycle is the (WAIT_LIMIT+1)th consecutive stall: abort.
          state_next = S_DONE;
          err_next   = 1'b1;
          wait_next  = '0;
        end else begin
          wait_next = wait_reg + CNT_W'(1);
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Select is registered alongside the state so DONE can keep the last bus address on the mux.
  always_comb begin
    sel_next = SEL_PCL;
    case (state_next)
      S_IDLE:     sel_next = SEL_PCL;
      S_FETCH:    sel_next = SEL_PCL;
      S_ZP:       sel_next = SEL_D;
      S_STK:      sel_next = SEL_S;
      S_IDX_LD:   sel_next = SEL_D;
      S_IDX_USE:  sel_next = SEL_L;
      S_IDX_USE2: sel_next = SEL_L;
      S_DONE:     sel_next = sel_reg;
      default:    sel_next = SEL_PCL;
    endcase
  end

  assign sel      = sel_reg;
  assign lreg_ld  = (state_reg == S_IDX_LD);
  assign addr_vld = bus_state;
  assign busy     = (state_reg != S_IDLE) && (state_reg != S_DONE);
  assign done     = (state_reg == S_DONE);
  assign err      = err_reg;

`ifdef ADL_SEQ_STALLCNT_EN
  logic [15:0] stall_cnt_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_reg <= 16'h0000;
    end else if (bus_state && !rdy && (stall_cnt_reg != 16'hFFFF)) begin
      stall_cnt_reg <= stall_cnt_reg + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_reg;
`else
  assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_adl_seq.sv
// Randomised self-checking bench for adl_seq: a phase-list reference model predicts the
// per-cycle sel/lreg_ld/addr_vld/busy/done/err trace of each request.
module tb_adl_seq;

  localparam int WL = 15;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [2:0]  mode;
  logic        rdy;
  logic [1:0]  sel;
  logic        lreg_ld;
  logic        addr_vld;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] stall_cnt;

  int errors = 0;
  int checks = 0;

  bit         rdy_pat[64];
  logic [6:0] exp_q[$];
  logic [6:0] obs_q[$];
  int         exp_stalls;
  int         stall_total = 0;

  adl_seq #(.WAIT_LIMIT(WL), .CNT_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .mode(mode), .rdy(rdy),
    .sel(sel), .lreg_ld(lreg_ld), .addr_vld(addr_vld), .busy(busy),
    .done(done), .err(err), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a request is a list of phases; internal phases take one cycle, bus phases
  // repeat while rdy is low, aborting after WL+1 consecutive stalls. Then DONE, then IDLE.
  task automatic build_exp(input logic [2:0] m);
    logic [1:0] psel[3];
    bit         pbus[3];
    int         n;
    int         k;
    int         run;
    bit         bad;
    logic [1:0] last_sel;
    exp_q.delete();
    exp_stalls = 0;
    bad = 1'b0;
    n = 0;
    case (m)
      3'd0: begin n = 1; psel[0] = 2'b00; pbus[0] = 1'b1; end
      3'd1: begin n = 1; psel[0] = 2'b01; pbus[0] = 1'b1; end
      3'd2: begin n = 1; psel[0] = 2'b10; pbus[0] = 1'b1; end
      3'd3, 3'd4: begin
        n = (m == 3'd4) ? 3 : 2;
        psel[0] = 2'b01; pbus[0] = 1'b0;
        psel[1] = 2'b11; pbus[1] = 1'b1;
        psel[2] = 2'b11; pbus[2] = 1'b1;
      end
      default: bad = 1'b1;
    endcase
    k = 1;
    last_sel = 2'b00;
    for (int p = 0; p < n && !bad; p++) begin
      last_sel = psel[p];
      if (!pbus[p]) begin
        exp_q.push_back({psel[p], 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
        k++;
      end else begin
        run = 0;
        forever begin
          exp_q.push_back({psel[p], 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
          if (rdy_pat[k]) begin
            k++;
            break;
          end
          k++;
          exp_stalls++;
          run++;
          if (run == WL + 1) begin
            bad = 1'b1;
            break;
          end
        end
      end
    end
    exp_q.push_back({last_sel, 1'b0, 1'b0, 1'b0, 1'b1, bad});
    exp_q.push_back(7'b0000000);
    stall_total += exp_stalls;
  endtask

  function automatic logic [15:0] exp_stall_cnt();
`ifdef ADL_SEQ_STALLCNT_EN
    if (stall_total > 65535) return 16'hFFFF;
    return 16'(stall_total);
`else
    return 16'h0000;
`endif
  endfunction

  // Called at #1 after an edge with the DUT idle; leaves the DUT idle the same way.
  task automatic drive_txn(input logic [2:0] m, input bit junk);
    obs_q.delete();
    start = 1'b1;
    mode  = m;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(posedge clk);
      #1;
      obs_q.push_back({sel, lreg_ld, addr_vld, busy, done, err});
      rdy = rdy_pat[i + 1];
      if (junk && (i < exp_q.size() - 1)) begin
        start = 1'($urandom);
        mode  = 3'($urandom);
      end else begin
        start = 1'b0;
      end
    end
  endtask

  task automatic set_rdy_all(input bit v);
    for (int j = 0; j < 64; j++) rdy_pat[j] = v;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    start = 1'b0;
    mode = 3'b000;
    rdy = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({sel, lreg_ld, addr_vld, busy, done, err} !== 7'b0000000) begin
      errors++;
      $display("FAIL reset_outputs: got %b required %b", {sel, lreg_ld, addr_vld, busy, done, err}, 7'b0000000);
    end
    checks++;
    if (stall_cnt !== 16'h0000) begin
      errors++;
      $display("FAIL reset_stall_cnt: got %h required 0000", stall_cnt);
    end
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("FAIL reset_idle_hold: got busy/done=%b required 00", {busy, done});
    end
    $display("test_reset: done");
  endtask

  task automatic test_fetch;
    set_rdy_all(1'b1);
    build_exp(3'b000);
    drive_txn(3'b000, 1'b0);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL fetch cyc%0d: got sel,ld,av,busy,done,err=%b required %b", i + 1, obs_q[i], exp_q[i]);
      end
    end
    $display("test_fetch: %0d cycles compared", exp_q.size());
  endtask

  task automatic test_zpx;
    set_rdy_all(1'b1);
    rdy_pat[1] = 1'b0;  // rdy is ignored during the internal index cycle
    build_exp(3'b011);
    drive_txn(3'b011, 1'b0);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL zpx cyc%0d: got sel,ld,av,busy,done,err=%b required %b", i + 1, obs_q[i], exp_q[i]);
      end
    end
    $display("test_zpx: %0d cycles compared", exp_q.size());
  endtask

  task automatic test_rmw_stall;
    set_rdy_all(1'b1);
    rdy_pat[3] = 1'b0;
    rdy_pat[4] = 1'b0;
    rdy_pat[5] = 1'b0;
    build_exp(3'b100);
    drive_txn(3'b100, 1'b0);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL rmw_stall cyc%0d: got sel,ld,av,busy,done,err=%b required %b", i + 1, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if (stall_cnt !== exp_stall_cnt()) begin
      errors++;
      $display("FAIL rmw_stall_cnt: got %0d required %0d", stall_cnt, exp_stall_cnt());
    end
    $display("test_rmw_stall: %0d cycles compared", exp_q.size());
  endtask

  task automatic test_watchdog;
    // Stalled forever: abort with err after WL+1 stall cycles.
    set_rdy_all(1'b0);
    build_exp(3'b001);
    drive_txn(3'b001, 1'b0);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL watchdog_abort cyc%0d: got sel,ld,av,busy,done,err=%b required %b", i + 1, obs_q[i], exp_q[i]);
      end
    end
    // Exactly WL stalls then ready: completes without error.
    set_rdy_all(1'b0);
    rdy_pat[WL + 1] = 1'b1;
    build_exp(3'b001);
    drive_txn(3'b001, 1'b0);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL watchdog_edge cyc%0d: got sel,ld,av,busy,done,err=%b required %b", i + 1, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if (stall_cnt !== exp_stall_cnt()) begin
      errors++;
      $display("FAIL watchdog_stall_cnt: got %0d required %0d", stall_cnt, exp_stall_cnt());
    end
    $display("test_watchdog: both bounds compared");
  endtask

  task automatic test_illegal;
    int done_seen;
    set_rdy_all(1'b1);
    for (int m = 5; m <= 7; m++) begin
      build_exp(3'(m));
      drive_txn(3'(m), 1'b0);
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL illegal_m%0d cyc%0d: got sel,ld,av,busy,done,err=%b required %b", m, i + 1, obs_q[i], exp_q[i]);
        end
      end
    end
    // Start strobes while busy must be ignored: one done pulse per request.
    set_rdy_all(1'b1);
    rdy_pat[2] = 1'b0;
    build_exp(3'b100);
    drive_txn(3'b100, 1'b1);
    done_seen = 0;
    for (int i = 0; i < obs_q.size(); i++) done_seen += int'(obs_q[i][1]);
    checks++;
    if (done_seen != 1) begin
      errors++;
      $display("FAIL ignore_start_done_count: got %0d required 1", done_seen);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL ignore_start cyc%0d: got sel,ld,av,busy,done,err=%b required %b", i + 1, obs_q[i], exp_q[i]);
      end
    end
    $display("test_illegal: illegal modes and ignored starts compared");
  endtask

  task automatic test_random;
    logic [2:0] m;
    for (int t = 0; t < 25; t++) begin
      m = 3'($urandom_range(0, 7));
      for (int j = 0; j < 64; j++) rdy_pat[j] = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 4) == 0) begin
        for (int j = 1; j < 22; j++) rdy_pat[j] = 1'b0;
      end
      build_exp(m);
      drive_txn(m, 1'b1);
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL random_t%0d_m%0d cyc%0d: got sel,ld,av,busy,done,err=%b required %b", t, m, i + 1, obs_q[i], exp_q[i]);
        end
      end
      checks++;
      if (stall_cnt !== exp_stall_cnt()) begin
        errors++;
        $display("FAIL random_t%0d_stall_cnt: got %0d required %0d", t, stall_cnt, exp_stall_cnt());
      end
      $display("test_random: txn %0d mode %0d len %0d stalls %0d", t, m, exp_q.size(), exp_stalls);
    end
  endtask

  task automatic test_reset_mid;
    set_rdy_all(1'b1);
    rdy = 1'b1;
    start = 1'b1;
    mode = 3'b011;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({sel, addr_vld} !== 3'b111) begin
      errors++;
      $display("FAIL mid_in_idx_use: got sel,av=%b required 111", {sel, addr_vld});
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({sel, lreg_ld, addr_vld, busy, done, err} !== 7'b0000000) begin
      errors++;
      $display("FAIL mid_async_reset: got %b required %b", {sel, lreg_ld, addr_vld, busy, done, err}, 7'b0000000);
    end
    checks++;
    if (stall_cnt !== 16'h0000) begin
      errors++;
      $display("FAIL mid_reset_stall_cnt: got %h required 0000", stall_cnt);
    end
    stall_total = 0;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      #1;
      checks++;
      if (done !== 1'b0) begin
        errors++;
        $display("FAIL mid_no_done_in_reset: got %b required 0", done);
      end
    end
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("FAIL mid_no_done_after: got busy,done=%b required 00", {busy, done});
    end
    build_exp(3'b010);
    drive_txn(3'b010, 1'b0);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL mid_stk cyc%0d: got sel,ld,av,busy,done,err=%b required %b", i + 1, obs_q[i], exp_q[i]);
      end
    end
    $display("test_reset_mid: abort and restart compared");
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_zpx();
    test_rmw_stall();
    test_watchdog();
    test_illegal();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
